mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mc_fetch_buf.sv | 39 +++
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller.
// Holds the FSM state enum, bus widths and the default timeout.
package mem_ctrl_pkg;

    localparam int MC_ADDR_W      = 32;
    localparam int MC_DATA_W      = 32;
    localparam int MC_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA
    } mc_state_e;

    function automatic logic [MC_ADDR_W-1:0] word_addr(
        input logic [MC_ADDR_W-1:0] a
    );
        return {a[MC_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mc_fetch_buf.sv
// One-entry instruction buffer keyed by word address.
// Filled by every completed fetch, dropped by a store to the same word.
module mc_fetch_buf
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MC_ADDR_W-3:0] lookup_i,
    output logic                 hit_o,
    output logic [MC_DATA_W-1:0] hit_data_o,
    input  logic                 upd_i,
    input  logic [MC_ADDR_W-3:0] upd_tag_i,
    input  logic [MC_DATA_W-1:0] upd_data_i,
    input  logic                 inv_i,
    input  logic [MC_ADDR_W-3:0] inv_tag_i
);

    logic [MC_ADDR_W-3:0] tag_q;
    logic [MC_DATA_W-1:0] data_q;
    logic                 valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (upd_i) begin
            tag_q   <= upd_tag_i;
            data_q  <= upd_data_i;
            valid_q <= 1'b1;
        end else if (inv_i && inv_tag_i == tag_q) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o      = valid_q && (lookup_i == tag_q);
    assign hit_data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates CPU fetch and load/store onto one memory port with timeout.
// MEM_CTRL_FETCH_BUF_EN adds a one-entry fetch buffer (mc_fetch_buf).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = MC_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MC_ADDR_W-1:0] instr_addr,
    output logic [MC_DATA_W-1:0] instr_data,
    output logic                 instr_valid,
    input  logic [MC_ADDR_W-1:0] data_addr,
    input  logic                 data_rd,
    input  logic                 data_wr,
    input  logic [MC_DATA_W-1:0] data_wdata,
    output logic [MC_DATA_W-1:0] data_rdata,
    output logic                 data_valid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [MC_ADDR_W-1:0] mem_addr,
    output logic [MC_DATA_W-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [MC_DATA_W-1:0] mem_rdata,
    output logic                 err
);

    localparam int CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    mc_state_e            state_q;
    logic                 req_q;
    logic                 we_q;
    logic [MC_ADDR_W-1:0] addr_q;
    logic [MC_DATA_W-1:0] wdata_q;
    logic [CntW-1:0]      cnt_q;
    logic [MC_DATA_W-1:0] idata_q;
    logic                 ivalid_q;
    logic [MC_DATA_W-1:0] rdata_q;
    logic                 dvalid_q;
    logic                 err_q;

    logic data_req;
    logic fetch_ok;
    logic tmo;

    assign data_req = data_rd | data_wr;
    assign fetch_ok = word_addr(instr_addr) == addr_q;
    assign tmo      = cnt_q == CntLast;

`ifdef MEM_CTRL_FETCH_BUF_EN
    logic                 buf_hit;
    logic [MC_DATA_W-1:0] buf_data;

    mc_fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_i   (instr_addr[MC_ADDR_W-1:2]),
        .hit_o      (buf_hit),
        .hit_data_o (buf_data),
        .upd_i      (state_q == ST_FETCH && mem_ack),
        .upd_tag_i  (addr_q[MC_ADDR_W-1:2]),
        .upd_data_i (mem_rdata),
        .inv_i      (state_q == ST_IDLE && data_wr),
        .inv_tag_i  (data_addr[MC_ADDR_W-1:2])
    );
`else
    wire                 buf_hit  = 1'b0;
    wire [MC_DATA_W-1:0] buf_data = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            idata_q  <= '0;
            ivalid_q <= 1'b0;
            rdata_q  <= '0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (data_req) begin
                        state_q <= ST_DATA;
                        req_q   <= 1'b1;
                        we_q    <= data_wr;
                        addr_q  <= word_addr(data_addr);
                        wdata_q <= data_wdata;
                    end else if (buf_hit) begin
                        ivalid_q <= 1'b1;
                        idata_q  <= buf_data;
                    end else begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= word_addr(instr_addr);
                        wdata_q <= '0;
                    end
                end
                ST_FETCH: begin
                    // a stale fetch (PC moved on) completes silently
                    if (mem_ack) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        if (fetch_ok) begin
                            ivalid_q <= 1'b1;
                            idata_q  <= mem_rdata;
                        end
                    end else if (tmo) begin
                        state_q  <= ST_IDLE;
                        req_q    <= 1'b0;
                        err_q    <= 1'b1;
                        ivalid_q <= 1'b1;
                        idata_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_DATA: begin
                    if (mem_ack) begin
                        state_q  <= ST_IDLE;
                        req_q    <= 1'b0;
                        dvalid_q <= 1'b1;
                        if (!we_q) rdata_q <= mem_rdata;
                    end else if (tmo) begin
                        state_q  <= ST_IDLE;
                        req_q    <= 1'b0;
                        err_q    <= 1'b1;
                        dvalid_q <= 1'b1;
                        if (!we_q) rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_data  = idata_q;
    assign instr_valid = ivalid_q;
    assign data_rdata  = rdata_q;
    assign data_valid  = dvalid_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: memory responder, transaction-level model
// checked every cycle, plus directed literal checks.
module tb_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr = '0;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic [31:0] data_addr = '0;
    logic        data_rd = 1'b0;
    logic        data_wr = 1'b0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    always #5 clk = ~clk;

    mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_addr  (instr_addr),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .data_addr   (data_addr),
        .data_rd     (data_rd),
        .data_wr     (data_wr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_valid  (data_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .err         (err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // memory responder
    int          ack_delay = 0;
    bit          ack_never = 0;
    bit          stray = 0;
    int          age = 0;
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] rd_mem(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return {w, 2'b00} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        #3;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if (!rst_n) begin
            age = 0;
        end else if (mem_req) begin
            if (!ack_never && age == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_mem(mem_addr[31:2]);
                if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
            end
            age++;
        end else begin
            age       = 0;
            mem_ack   = stray;
            mem_rdata = stray ? 32'hBAD0_BAD0 : 32'h0;
        end
    end

    // transaction-level model, compared every cycle
    bit          p_rst = 1;
    logic        p_ack, p_rd, p_wr;
    logic [31:0] p_rdata, p_daddr, p_dwdata, p_iaddr;
    bit          m_busy = 0;
    bit          m_data = 0;
    bit          t_we = 0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wd = '0;
    int          cnt = 0;
    bit          e_err = 0;
    logic [31:0] hold = '0;
    bit          b_val = 0;
    logic [29:0] b_tag = '0;
    logic [31:0] b_dat = '0;
    bit          e_req, e_iv, e_dv;
    logic [31:0] e_id;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_data_valid", data_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_data_rdata", data_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            m_busy = 0; cnt = 0; e_err = 0; hold = '0; b_val = 0;
            p_rst = 1;
        end else begin
            e_req = 0; e_iv = 0; e_dv = 0; e_id = '0;
            if (p_rst) begin
                e_req = 0;
            end else if (m_busy && p_ack) begin
                m_busy = 0; cnt = 0;
                if (m_data) begin
                    e_dv = 1;
                    if (!t_we) hold = p_rdata;
                end else begin
                    if (p_iaddr[31:2] == t_addr[31:2]) begin
                        e_iv = 1; e_id = p_rdata;
                    end
`ifdef MEM_CTRL_FETCH_BUF_EN
                    b_val = 1; b_tag = t_addr[31:2]; b_dat = p_rdata;
`endif
                end
            end else if (m_busy && cnt >= TO) begin
                m_busy = 0; cnt = 0; e_err = 1;
                if (m_data) begin
                    e_dv = 1;
                    if (!t_we) hold = '0;
                end else begin
                    e_iv = 1; e_id = '0;
                end
            end else if (m_busy) begin
                e_req = 1;
            end else if (p_rd || p_wr) begin
                m_busy = 1; m_data = 1; cnt = 0; e_req = 1;
                t_addr = {p_daddr[31:2], 2'b00};
                t_we = p_wr; t_wd = p_dwdata;
                if (p_wr && b_tag == p_daddr[31:2]) b_val = 0;
            end else if (b_val && b_tag == p_iaddr[31:2]) begin
                e_iv = 1; e_id = b_dat;
            end else begin
                m_busy = 1; m_data = 0; cnt = 0; e_req = 1;
                t_addr = {p_iaddr[31:2], 2'b00};
                t_we = 0;
            end
            chk("mdl_mem_req", mem_req, e_req);
            chk("mdl_instr_valid", instr_valid, e_iv);
            chk("mdl_data_valid", data_valid, e_dv);
            chk("mdl_err", err, e_err);
            chk("mdl_data_rdata", data_rdata, hold);
            if (e_iv) chk("mdl_instr_data", instr_data, e_id);
            if (e_req) begin
                chk("mdl_mem_addr", mem_addr, t_addr);
                chk("mdl_mem_we", mem_we, t_we);
                if (t_we) chk("mdl_mem_wdata", mem_wdata, t_wd);
            end
            if (m_busy && !mem_ack) cnt++;
            p_rst = 0;
        end
        p_ack = mem_ack; p_rdata = mem_rdata;
        p_rd = data_rd; p_wr = data_wr;
        p_daddr = data_addr; p_dwdata = data_wdata;
        p_iaddr = instr_addr;
    end

    // directed stimulus
    int cyc = 0;

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk); #2;
            cyc++;
        end
    endtask

    task automatic rst_on();
        @(posedge clk); #2;
        rst_n = 0;
        data_rd = 0; data_wr = 0; data_addr = '0; data_wdata = '0;
        instr_addr = '0;
        ack_delay = 0; ack_never = 0; stray = 0;
    endtask

    task automatic rst_off();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        logic pr;
        mem[30'h40] = 32'hDEAD_BEEF;
        instr_addr = 32'h100;
        @(negedge clk);
        chk("init_reset_req", mem_req, 0);
        chk("init_reset_err", err, 0);
        rst_off();

        // fetch 0x100, immediate ack
        @(negedge clk); chk("f100_c0_req", mem_req, 0);
        goto(1); @(negedge clk);
        chk("f100_c1_req", mem_req, 1);
        chk("f100_c1_addr", mem_addr, 32'h100);
        goto(2); @(negedge clk);
        chk("f100_c2_ivalid", instr_valid, 1);
        chk("f100_c2_idata", instr_data, 32'hDEAD_BEEF);
        chk("f100_c2_req", mem_req, 0);

        // store beats pending fetch, then load back
        rst_on();
        ack_delay = 3; instr_addr = 32'h300;
        data_wr = 1; data_addr = 32'h2003; data_wdata = 32'h55AA;
        rst_off();
        goto(1); @(negedge clk);
        chk("wr_c1_req", mem_req, 1);
        chk("wr_c1_addr", mem_addr, 32'h2000);
        chk("wr_c1_we", mem_we, 1);
        chk("wr_c1_wdata", mem_wdata, 32'h55AA);
        goto(4); @(negedge clk);
        chk("wr_c4_dvalid", data_valid, 0);
        goto(5); data_wr = 0; @(negedge clk);
        chk("wr_c5_dvalid", data_valid, 1);
        chk("wr_c5_req", mem_req, 0);
        goto(6); @(negedge clk);
        chk("wr_c6_fetch_req", mem_req, 1);
        chk("wr_c6_fetch_addr", mem_addr, 32'h300);
        chk("wr_c6_fetch_we", mem_we, 0);
        goto(7); data_rd = 1; data_addr = 32'h2001;
        goto(10); @(negedge clk);
        chk("wr_c10_ivalid", instr_valid, 1);
        chk("wr_c10_idata", instr_data, 32'h5A5A_0300);
        goto(11); @(negedge clk);
        chk("rd_c11_addr", mem_addr, 32'h2000);
        chk("rd_c11_we", mem_we, 0);
        goto(12); data_rd = 0;
        goto(15); @(negedge clk);
        chk("rd_c15_dvalid", data_valid, 1);
        chk("rd_c15_rdata", data_rdata, 32'h55AA);

        // PC moves during fetch
        rst_on();
        ack_delay = 2; instr_addr = 32'h10;
        rst_off();
        goto(1); @(negedge clk);
        chk("pc_c1_addr", mem_addr, 32'h10);
        goto(2); instr_addr = 32'h20;
        goto(4); @(negedge clk);
        chk("pc_c4_no_ivalid", instr_valid, 0);
        goto(5); @(negedge clk);
        chk("pc_c5_req", mem_req, 1);
        chk("pc_c5_addr", mem_addr, 32'h20);
        goto(8); @(negedge clk);
        chk("pc_c8_ivalid", instr_valid, 1);
        chk("pc_c8_idata", instr_data, 32'h5A5A_0020);

        // timeout, then reset mid-fetch
        rst_on();
        ack_never = 1; instr_addr = 32'h80;
        rst_off();
        goto(4); @(negedge clk);
        chk("to_c4_req", mem_req, 1);
        goto(5); @(negedge clk);
        chk("to_c5_req", mem_req, 0);
        chk("to_c5_err", err, 1);
        chk("to_c5_ivalid", instr_valid, 1);
        chk("to_c5_idata", instr_data, 0);
        goto(6); @(negedge clk);
        chk("to_c6_err", err, 1);
        chk("to_c6_req", mem_req, 1);
        goto(11); @(negedge clk);
        chk("to_c11_err_sticky", err, 1);
        chk("to_c11_req", mem_req, 1);
        rst_on();
        @(negedge clk);
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_err", err, 0);

        // ack while idle is ignored
        ack_delay = 1; stray = 1; instr_addr = 32'h400;
        rst_off();
        goto(12);

`ifdef MEM_CTRL_FETCH_BUF_EN
        rst_on();
        instr_addr = 32'h40;
        rst_off();
        nreq = 0; pr = 0;
        for (int c = 0; c <= 8; c++) begin
            goto(c); @(negedge clk);
            if (mem_req && !pr && !mem_we) nreq++;
            pr = mem_req;
        end
        chk("buf_one_fetch", nreq, 1);
        goto(9); data_wr = 1; data_addr = 32'h40; data_wdata = 32'h1234;
        goto(10); data_wr = 0;
        nreq = 0;
        for (int c = 10; c <= 14; c++) begin
            goto(c); @(negedge clk);
            if (mem_req && !pr && !mem_we) nreq++;
            if (c == 13) chk("buf_refetch_data", instr_data, 32'h1234);
            pr = mem_req;
        end
        chk("buf_refetch_after_store", nreq, 1);
`endif

        goto(cyc + 3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
